// File: rtl/sid_stream_ctrl.sv
// SID register-write streamer: parses {address, data} byte pairs, queues them and issues
// one write per clk_en strobe. Define SID_STREAM_STATS_EN to build wr_count/drop_count.
module sid_stream_ctrl #(
    parameter int unsigned NUM_SID     = 1,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                        clk,
    input  logic                        n_reset,
    input  logic                        clk_en,
    input  logic [7:0]                  s_tdata,
    input  logic                        s_tvalid,
    output logic                        s_tready,
    output logic [4:0]                  sid_addr,
    output logic [7:0]                  sid_data,
    output logic [NUM_SID-1:0]          sid_n_cs,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 wr_count,
    output logic [7:0]                  drop_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic {
        ST_ADDR = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0] chip;
        logic [4:0] reg_a;
        logic [7:0] data;
    } wr_entry_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [TW-1:0]   r_tmo;
    logic [TW-1:0]   w_tmo_nx;
    logic [1:0]      r_chip;
    logic [4:0]      r_reg;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    wr_entry_t       r_mem [FIFO_DEPTH];
    wr_entry_t       w_head;
    logic [NUM_SID-1:0] w_cs_sel;
    logic            w_full;
    logic            w_empty;
    logic            w_accept;
    logic            w_addr_ok;
    logic            w_tmo_hit;
    logic            w_latch;
    logic            w_push;
    logic            w_pop;

    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    assign s_tready  = (r_state == ST_ADDR) || !w_full;
    assign w_accept  = s_tvalid && s_tready;
    assign w_addr_ok = !s_tdata[7] && ({1'b0, s_tdata[6:5]} < 3'(NUM_SID));
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYC - 1));
    assign w_pop     = clk_en && !w_empty;
    assign w_head    = r_mem[r_rd_ptr];
    assign fifo_level = r_level;

    // Parser next-state: address byte, then data byte, with a timeout while waiting for data
    always_comb begin
        w_state_nx = r_state;
        w_tmo_nx   = r_tmo;
        w_latch    = 1'b0;
        w_push     = 1'b0;
        case (r_state)
            ST_ADDR: begin
                w_tmo_nx = '0;
                if (w_accept && w_addr_ok) begin
                    w_state_nx = ST_DATA;
                    w_latch    = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    w_push     = 1'b1;
                    w_state_nx = ST_ADDR;
                    w_tmo_nx   = '0;
                end else if (w_tmo_hit) begin
                    w_state_nx = ST_ADDR;
                    w_tmo_nx   = '0;
                end else begin
                    w_tmo_nx = r_tmo + TW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= ST_ADDR;
            r_tmo   <= '0;
            r_chip  <= '0;
            r_reg   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_tmo   <= w_tmo_nx;
            if (w_latch) begin
                r_chip <= s_tdata[6:5];
                r_reg  <= s_tdata[4:0];
            end
        end
    end

    // Queue storage carries no reset; validity is tracked by the pointers and level
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{chip: r_chip, reg_a: r_reg, data: s_tdata};
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_comb begin
        w_cs_sel = '1;
        for (int i = 0; i < NUM_SID; i++) begin
            w_cs_sel[i] = (w_head.chip != 2'(i));
        end
    end

    // Bus outputs move only on strobe edges so each write holds for a full clk_en period
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sid_addr <= '0;
            sid_data <= '0;
            sid_n_cs <= '1;
        end else if (clk_en) begin
            if (!w_empty) begin
                sid_addr <= w_head.reg_a;
                sid_data <= w_head.data;
                sid_n_cs <= w_cs_sel;
            end else begin
                sid_n_cs <= '1;
            end
        end
    end

`ifdef SID_STREAM_STATS_EN
    logic [15:0] r_wr_cnt;
    logic [7:0]  r_drop_cnt;
    logic        w_drop;

    assign w_drop = ((r_state == ST_ADDR) && w_accept && !w_addr_ok) ||
                    ((r_state == ST_DATA) && !w_accept && w_tmo_hit);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_pop) r_wr_cnt <= r_wr_cnt + 16'd1;
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign wr_count   = r_wr_cnt;
    assign drop_count = r_drop_cnt;
`else
    assign wr_count   = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_sid_stream_ctrl.sv
// Bench for sid_stream_ctrl: directed vector table, corner sequences and a randomized run
// compared every cycle against a queue-based reference model.
module tb_sid_stream_ctrl;

    localparam int NSID = 2;
    localparam int DEPTH = 16;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        clk_en;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [4:0]  sid_addr;
    logic [7:0]  sid_data;
    logic [1:0]  sid_n_cs;
    logic [4:0]  fifo_level;
    logic [15:0] wr_count;
    logic [7:0]  drop_count;

    sid_stream_ctrl #(
        .NUM_SID    (NSID),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .clk_en    (clk_en),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .sid_addr  (sid_addr),
        .sid_data  (sid_data),
        .sid_n_cs  (sid_n_cs),
        .fifo_level(fifo_level),
        .wr_count  (wr_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a parser flag, a wait counter and a queue of pending writes
    typedef struct packed {
        logic [1:0] chip;
        logic [4:0] ra;
        logic [7:0] d;
    } ent_t;

    ent_t       mq[$];
    bit         m_in_data;
    int         m_wait;
    logic [1:0] m_chip;
    logic [4:0] m_ra;
    logic [4:0] m_addr;
    logic [7:0] m_data;
    logic [1:0] m_cs;
    int         m_wr;
    int         m_drop;

    function automatic bit addr_ok(input logic [7:0] b);
        return (b[7] == 1'b0) && (int'(b[6:5]) < NSID);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_in_data = 0;
        m_wait = 0;
        m_chip = '0;
        m_ra = '0;
        m_addr = '0;
        m_data = '0;
        m_cs = 2'b11;
        m_wr = 0;
        m_drop = 0;
    endtask

    task automatic note_drop();
        if (m_drop < 255) m_drop++;
    endtask

    task automatic model_step();
        ent_t e;
        bit   ready;
        bit   acc;
        ready = !m_in_data || (mq.size() < DEPTH);
        acc = s_tvalid && ready;
        if (clk_en) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_addr = e.ra;
                m_data = e.d;
                m_cs = 2'b11;
                m_cs[e.chip] = 1'b0;
                m_wr++;
            end else begin
                m_cs = 2'b11;
            end
        end
        if (!m_in_data) begin
            if (acc) begin
                if (addr_ok(s_tdata)) begin
                    m_in_data = 1;
                    m_wait = 0;
                    m_chip = s_tdata[6:5];
                    m_ra = s_tdata[4:0];
                end else begin
                    note_drop();
                end
            end
        end else if (acc) begin
            mq.push_back('{chip: m_chip, ra: m_ra, d: s_tdata});
            m_in_data = 0;
        end else begin
            m_wait++;
            if (m_wait >= TMO) begin
                m_in_data = 0;
                note_drop();
            end
        end
    endtask

    task automatic check_model();
        chk("mdl_addr", sid_addr, m_addr);
        chk("mdl_data", sid_data, m_data);
        chk("mdl_cs", sid_n_cs, m_cs);
        chk("mdl_level", fifo_level, mq.size());
        chk("mdl_ready", s_tready, (!m_in_data || mq.size() < DEPTH) ? 1 : 0);
`ifdef SID_STREAM_STATS_EN
        chk("mdl_wr_count", wr_count, m_wr & 16'hFFFF);
        chk("mdl_drop_count", drop_count, m_drop);
`else
        chk("mdl_wr_count", wr_count, 0);
        chk("mdl_drop_count", drop_count, 0);
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic send(input logic [7:0] b);
        s_tvalid = 1'b1;
        s_tdata = b;
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        clk_en = 1'b0;
        n_reset = 1'b0;
        model_reset();
        #1;
        chk("rst_cs_now", sid_n_cs, 2'b11);
        chk("rst_level_now", fifo_level, 0);
        chk("rst_addr_now", sid_addr, 0);
        chk("rst_data_now", sid_data, 0);
        @(posedge clk);
        #1;
        check_model();
        n_reset = 1'b1;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       en;
        logic [1:0] cs;
        logic [4:0] a;
        logic [7:0] dat;
        int         lvl;
        logic       rdy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int nw;
        logic [7:0] b;

        tbl[0]  = '{1'b1, 8'h38, 1'b0, 2'b11, 5'h00, 8'h00, 0, 1'b1};
        tbl[1]  = '{1'b1, 8'h0F, 1'b0, 2'b11, 5'h00, 8'h00, 1, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 2'b01, 5'h18, 8'h0F, 0, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 2'b01, 5'h18, 8'h0F, 0, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 2'b01, 5'h18, 8'h0F, 0, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 2'b11, 5'h18, 8'h0F, 0, 1'b1};
        tbl[6]  = '{1'b1, 8'h45, 1'b0, 2'b11, 5'h18, 8'h0F, 0, 1'b1};
        tbl[7]  = '{1'b1, 8'h80, 1'b0, 2'b11, 5'h18, 8'h0F, 0, 1'b1};
        tbl[8]  = '{1'b1, 8'h04, 1'b0, 2'b11, 5'h18, 8'h0F, 0, 1'b1};
        tbl[9]  = '{1'b1, 8'h11, 1'b0, 2'b11, 5'h18, 8'h0F, 1, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 2'b10, 5'h04, 8'h11, 0, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 2'b11, 5'h04, 8'h11, 0, 1'b1};

        n_reset = 1'b0;
        clk_en = 1'b0;
        s_tvalid = 1'b0;
        s_tdata = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        chk("reset_ready", s_tready, 1);
        n_reset = 1'b1;

        // Directed vectors: chip-1 write, then invalid addresses followed by a chip-0 write
        for (int i = 0; i < 12; i++) begin
            s_tvalid = tbl[i].v;
            s_tdata = tbl[i].d;
            clk_en = tbl[i].en;
            tick();
            chk($sformatf("tbl%0d_cs", i), sid_n_cs, tbl[i].cs);
            chk($sformatf("tbl%0d_addr", i), sid_addr, tbl[i].a);
            chk($sformatf("tbl%0d_data", i), sid_data, tbl[i].dat);
            chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].lvl);
            chk($sformatf("tbl%0d_ready", i), s_tready, tbl[i].rdy);
        end
        s_tvalid = 1'b0;
        clk_en = 1'b0;
`ifdef SID_STREAM_STATS_EN
        chk("tbl_drop_count", drop_count, 2);
        chk("tbl_wr_count", wr_count, 2);
`else
        chk("tbl_drop_count", drop_count, 0);
        chk("tbl_wr_count", wr_count, 0);
`endif

        // Fill the queue with strobes stopped, then drain on consecutive strobes
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 31));
            b[5] = 1'($urandom_range(0, 1));
            send(b);
            send(8'($urandom));
        end
        chk("full_level", fifo_level, DEPTH);
        send(8'h21);
        chk("full_ready_data", s_tready, 0);
        nw = 0;
        for (int k = 0; k < 68; k++) begin
            clk_en = (k % 4 == 0);
            tick();
            if (k % 4 == 0 && k < 64) chk($sformatf("burst_strobe%0d", k / 4), (sid_n_cs != 2'b11) ? 1 : 0, 1);
            if (k % 4 == 0 && sid_n_cs != 2'b11) nw++;
        end
        clk_en = 1'b0;
        chk("burst_writes", nw, DEPTH);
        chk("burst_level", fifo_level, 0);
        repeat (60) tick();

        // Timeout: 100 idle cycles abandons the pair, 99 do not
        send(8'h01);
        repeat (TMO) tick();
        send(8'h02);
        send(8'h33);
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        chk("tmo_addr", sid_addr, 5'h02);
        chk("tmo_data", sid_data, 8'h33);
        chk("tmo_cs", sid_n_cs, 2'b10);
        chk("tmo_level", fifo_level, 0);
        send(8'h03);
        repeat (TMO - 1) tick();
        send(8'h44);
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        chk("tmo_edge_addr", sid_addr, 5'h03);
        chk("tmo_edge_data", sid_data, 8'h44);
        chk("tmo_edge_cs", sid_n_cs, 2'b10);

        // Reset with writes queued and one in flight
        for (int i = 1; i <= 3; i++) begin
            send(8'(i));
            send(8'(8'hA0 + i));
        end
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        chk("pre_rst_cs", sid_n_cs, 2'b10);
        tick();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            clk_en = (k % 4 == 0);
            tick();
            chk($sformatf("post_rst_cs%0d", k), sid_n_cs, 2'b11);
        end
        chk("post_rst_level", fifo_level, 0);

        // Randomized traffic with slow and fast strobe phases and idle gaps
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 >= 380 && k % 500 < 490) begin
                s_tvalid = 1'b0;
            end else begin
                s_tvalid = ($urandom_range(0, 3) != 0);
            end
            s_tdata = 8'($urandom);
            if ($urandom_range(0, 2) != 0) s_tdata[7:6] = 2'b00;
            if (k < 1500) clk_en = ($urandom_range(0, 7) == 0);
            else clk_en = ($urandom_range(0, 1) == 0);
            tick();
        end
        s_tvalid = 1'b0;
        clk_en = 1'b1;
        repeat (DEPTH + 2) tick();
        chk("final_level", fifo_level, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
